// File: rtl/mean_pkg.sv
// Shared definitions for the time-multiplexed class scorer.
// Provides the pixel-window geometry, the register-file index of the bias
// entry, the default score width, the controller state encoding and the
// signed score type used by mean_scheduler and mean_weight_rf.
package mean_pkg;

    localparam int N_PIX       = 9;   // pixels in a 3x3 window
    localparam int BIAS_IDX    = 9;   // register-file column holding the bias
    localparam int DEF_W_WIDTH = 20;  // default weight / bias / score width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } mean_state_t;

    typedef logic signed [DEF_W_WIDTH-1:0] score_t;

endpackage

// File: rtl/mean_weight_rf.sv
// Weight/bias store: N_CLASS rows of ten signed entries (nine pixel weights
// followed by the bias). Synchronous active-high reset clears every entry.
// Ports:
//   clk, rst          clock, synchronous reset
//   we                write strobe (already qualified by the caller's state)
//   wr_class, wr_idx  write address; out-of-range addresses are dropped
//   wr_data           written value
//   rd_class, rd_idx  combinational read address
//   rd_weight         entry (rd_class, rd_idx)
//   rd_bias           bias entry of rd_class, read alongside the weight so the
//                     first pixel term and the bias can be summed in one cycle
module mean_weight_rf
    import mean_pkg::*;
#(
    parameter int N_CLASS = 4,
    parameter int W_WIDTH = DEF_W_WIDTH,
    localparam int CW     = $clog2(N_CLASS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [CW-1:0]             wr_class,
    input  logic [3:0]                wr_idx,
    input  logic signed [W_WIDTH-1:0] wr_data,
    input  logic [CW-1:0]             rd_class,
    input  logic [3:0]                rd_idx,
    output logic signed [W_WIDTH-1:0] rd_weight,
    output logic signed [W_WIDTH-1:0] rd_bias
);

    logic signed [W_WIDTH-1:0] mem_r [N_CLASS][BIAS_IDX+1];
    logic                      wr_ok_s;

    // Qualify the write: index must be a weight or the bias, class must exist.
    always_comb begin
        wr_ok_s = we
                  && (wr_idx <= 4'(BIAS_IDX))
                  && ({1'b0, wr_class} < (CW+1)'(N_CLASS));
    end

    // Storage array: cleared on reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CLASS; i++) begin
                for (int j = 0; j <= BIAS_IDX; j++) begin
                    mem_r[i][j] <= {W_WIDTH{1'b0}};
                end
            end
        end else if (wr_ok_s) begin
            mem_r[wr_class][wr_idx] <= wr_data;
        end
    end

    assign rd_weight = mem_r[rd_class][rd_idx];
    assign rd_bias   = mem_r[rd_class][BIAS_IDX];

endmodule

// File: rtl/mean_scheduler.sv
// Time-multiplexed class scorer. One accumulator walks the nine pixels of a
// latched 3x3 binary window for each class in turn (one pixel per cycle),
// adds the class bias, and tracks the arg-max class. Ties keep the lower
// class index; the running best is seeded from class 0. All sums wrap
// modulo 2^W_WIDTH.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_we/cfg_class/cfg_idx/cfg_data  weight/bias write, honoured only in IDLE
//   in_valid/in_ready/in_pix     pixel-window handshake (bit k = pixel k)
//   out_valid/out_ready          result handshake
//   out_class/out_score          winning class and its score, held in DONE
module mean_scheduler
    import mean_pkg::*;
#(
    parameter int N_CLASS = 4,
    parameter int W_WIDTH = DEF_W_WIDTH,
    localparam int CW     = $clog2(N_CLASS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [CW-1:0]             cfg_class,
    input  logic [3:0]                cfg_idx,
    input  logic signed [W_WIDTH-1:0] cfg_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_PIX-1:0]          in_pix,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CW-1:0]             out_class,
    output logic signed [W_WIDTH-1:0] out_score
);

    mean_state_t               state_r;
    mean_state_t               state_nx_s;

    logic [N_PIX-1:0]          pix_r;
    logic [CW-1:0]             c_r;
    logic [3:0]                k_r;
    logic signed [W_WIDTH-1:0] acc_r;
    logic signed [W_WIDTH-1:0] best_r;
    logic [CW-1:0]             best_idx_r;
    logic                      out_valid_r;
    logic [CW-1:0]             out_class_r;
    logic signed [W_WIDTH-1:0] out_score_r;

    logic                      rf_we_s;
    logic signed [W_WIDTH-1:0] w_s;
    logic signed [W_WIDTH-1:0] bias_s;
    logic signed [W_WIDTH-1:0] term_s;
    logic signed [W_WIDTH-1:0] base_s;
    logic signed [W_WIDTH-1:0] sum_s;
    logic                      take_s;
    logic signed [W_WIDTH-1:0] best_nx_s;
    logic [CW-1:0]             best_idx_nx_s;
    logic                      last_pix_s;
    logic                      last_class_s;

    // Config writes only land while idle; this also covers the write that
    // shares an edge with an input handshake, so that window sees it.
    assign rf_we_s = cfg_we && (state_r == S_IDLE);

    mean_weight_rf #(
        .N_CLASS (N_CLASS),
        .W_WIDTH (W_WIDTH)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we_s),
        .wr_class  (cfg_class),
        .wr_idx    (cfg_idx),
        .wr_data   (cfg_data),
        .rd_class  (c_r),
        .rd_idx    (k_r),
        .rd_weight (w_s),
        .rd_bias   (bias_s)
    );

    assign last_pix_s   = (k_r == 4'(N_PIX - 1));
    assign last_class_s = (c_r == CW'(N_CLASS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx_s = S_ACCUM;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (last_pix_s && last_class_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_ACCUM;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Pixel term, running sum (bias enters on the first pixel) and arg-max
    // update; strict greater-than keeps the lower index on a tie.
    always_comb begin
        term_s        = {W_WIDTH{1'b0}};
        base_s        = acc_r;
        take_s        = 1'b0;
        best_nx_s     = best_r;
        best_idx_nx_s = best_idx_r;
        if (pix_r[k_r]) begin
            term_s = w_s;
        end else begin
            term_s = {W_WIDTH{1'b0}};
        end
        if (k_r == 4'd0) begin
            base_s = bias_s;
        end else begin
            base_s = acc_r;
        end
        sum_s  = base_s + term_s;
        take_s = (c_r == {CW{1'b0}}) || (sum_s > best_r);
        if (take_s) begin
            best_nx_s     = sum_s;
            best_idx_nx_s = c_r;
        end else begin
            best_nx_s     = best_r;
            best_idx_nx_s = best_idx_r;
        end
    end

    // Datapath registers: window latch, counters, accumulator, arg-max and
    // the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_r       <= {N_PIX{1'b0}};
            c_r         <= {CW{1'b0}};
            k_r         <= 4'd0;
            acc_r       <= {W_WIDTH{1'b0}};
            best_r      <= {W_WIDTH{1'b0}};
            best_idx_r  <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            out_class_r <= {CW{1'b0}};
            out_score_r <= {W_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        pix_r <= in_pix;
                        c_r   <= {CW{1'b0}};
                        k_r   <= 4'd0;
                    end
                end
                S_ACCUM: begin
                    acc_r <= sum_s;
                    if (last_pix_s) begin
                        best_r     <= best_nx_s;
                        best_idx_r <= best_idx_nx_s;
                        k_r        <= 4'd0;
                        c_r        <= c_r + CW'(1);
                        if (last_class_s) begin
                            out_valid_r <= 1'b1;
                            out_class_r <= best_idx_nx_s;
                            out_score_r <= best_nx_s;
                        end
                    end else begin
                        k_r <= k_r + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = out_valid_r;
    assign out_class = out_class_r;
    assign out_score = out_score_r;

endmodule

// File: tb/tb_mean_scheduler.sv
// Directed bench for mean_scheduler with a score model built from the
// weight table kept in the bench.
module tb_mean_scheduler;

    localparam int N_CLASS = 4;
    localparam int W_WIDTH = 20;
    localparam int CW      = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cfg_we;
    logic [CW-1:0]             cfg_class;
    logic [3:0]                cfg_idx;
    logic signed [W_WIDTH-1:0] cfg_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [8:0]                in_pix;
    logic                      out_valid;
    logic                      out_ready;
    logic [CW-1:0]             out_class;
    logic signed [W_WIDTH-1:0] out_score;

    mean_scheduler #(.N_CLASS(N_CLASS), .W_WIDTH(W_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_score(out_score)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wm [N_CLASS][10];
    int exp_class, exp_score;
    bit pending = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic int wrap(input int s);
        logic [W_WIDTH-1:0] t;
        t = s[W_WIDTH-1:0];
        return int'($signed(t));
    endfunction

    function automatic int model_score(input int c, input logic [8:0] p);
        int s;
        s = wm[c][9];
        for (int k = 0; k < 9; k++) if (p[k]) s += wm[c][k];
        return wrap(s);
    endfunction

    task automatic model_argmax(input logic [8:0] p, output int bc, output int bs);
        int s;
        bc = 0;
        bs = model_score(0, p);
        for (int c = 1; c < N_CLASS; c++) begin
            s = model_score(c, p);
            if (s > bs) begin
                bs = s;
                bc = c;
            end
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < N_CLASS; c++)
            for (int k = 0; k < 10; k++) wm[c][k] = 0;
    endtask

    // Result checker: whenever a result is presented it must be expected
    // and match the model; the input side must stay closed meanwhile.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("result_expected", int'(pending), 1);
            chk("out_class", int'(out_class), exp_class);
            chk("out_score", int'(out_score), exp_score);
            chk("in_ready_done", int'(in_ready), 0);
        end
    end

    task automatic cfg_write(input int c, input int i, input int d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_class = c[CW-1:0];
        cfg_idx   = i[3:0];
        cfg_data  = d[W_WIDTH-1:0];
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        wm[c][i] = d;
    endtask

    task automatic start_window(input logic [8:0] pix, input bit sc,
                                input int sc_c, input int sc_i, input int sc_d);
        @(negedge clk);
        in_valid = 1'b1;
        in_pix   = pix;
        if (sc) begin
            cfg_we    = 1'b1;
            cfg_class = sc_c[CW-1:0];
            cfg_idx   = sc_i[3:0];
            cfg_data  = sc_d[W_WIDTH-1:0];
            wm[sc_c][sc_i] = sc_d;
        end
        chk("in_ready_idle", int'(in_ready), 1);
        model_argmax(pix, exp_class, exp_score);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        pending  = 1'b1;
    endtask

    task automatic run_window(input logic [8:0] pix, input int hold, input bit poke,
                              input bit sc, input int sc_c, input int sc_i, input int sc_d,
                              output int got_c, output int got_s, output int lat);
        start_window(pix, sc, sc_c, sc_i, sc_d);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            if (poke && (lat == 5 || lat == 6)) begin
                in_valid  = 1'b1;
                cfg_we    = 1'b1;
                cfg_class = 2'd0;
                cfg_idx   = 4'd0;
                cfg_data  = 20'sd12345;
                chk("in_ready_accum", int'(in_ready), 0);
            end else begin
                in_valid = 1'b0;
                cfg_we   = 1'b0;
            end
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        chk("result_timeout", int'(out_valid), 1);
        got_c = int'(out_class);
        got_s = int'(out_score);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (poke && i == 3) begin
                in_valid = 1'b1;
                cfg_we   = 1'b1;
                cfg_data = 20'sd777;
            end else begin
                in_valid = 1'b0;
                cfg_we   = 1'b0;
            end
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        pending   = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
    endtask

    int gc, gs, lat;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_class = 2'd0; cfg_idx = 4'd0; cfg_data = 20'sd0;
        in_valid = 1'b0; in_pix = 9'h000; out_ready = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_class", int'(out_class), 0);
        chk("reset_out_score", int'(out_score), 0);
        chk("reset_in_ready",  int'(in_ready), 1);

        // Full window: scores 9, 13, 3, -9.
        for (int c = 0; c < N_CLASS; c++)
            for (int k = 0; k < 9; k++)
                cfg_write(c, k, (c == 0) ? 1 : (c == 1) ? 2 : (c == 2) ? 0 : -1);
        cfg_write(1, 9, -5);
        cfg_write(2, 9, 3);
        chk("model_c0", model_score(0, 9'h1FF), 9);
        chk("model_c1", model_score(1, 9'h1FF), 13);
        chk("model_c2", model_score(2, 9'h1FF), 3);
        chk("model_c3", model_score(3, 9'h1FF), -9);
        run_window(9'h1FF, 0, 1'b0, 1'b0, 0, 0, 0, gc, gs, lat);
        chk("full_class", gc, 1);
        chk("full_score", gs, 13);
        chk("full_latency", lat, 37);

        // All negative scores.
        cfg_write(0, 9, -1); cfg_write(1, 9, -2); cfg_write(2, 9, -3); cfg_write(3, 9, -4);
        run_window(9'h000, 0, 1'b0, 1'b0, 0, 0, 0, gc, gs, lat);
        chk("neg_class", gc, 0);
        chk("neg_score", gs, -1);

        // Tie between classes 0 and 2.
        cfg_write(0, 9, 5); cfg_write(1, 9, 4); cfg_write(2, 9, 5); cfg_write(3, 9, 3);
        run_window(9'h000, 0, 1'b0, 1'b0, 0, 0, 0, gc, gs, lat);
        chk("tie_class", gc, 0);
        chk("tie_score", gs, 5);

        // Wrap: 0x7FFFF + 0x7FFFF = -2.
        cfg_write(0, 0, 524287); cfg_write(0, 1, 524287); cfg_write(0, 9, 0);
        cfg_write(1, 9, -100000); cfg_write(2, 9, -100000); cfg_write(3, 9, -100000);
        chk("model_wrap", model_score(0, 9'h003), -2);
        run_window(9'h003, 0, 1'b0, 1'b0, 0, 0, 0, gc, gs, lat);
        chk("wrap_class", gc, 0);
        chk("wrap_score", gs, -2);

        // Backpressure with ignored writes/windows, then confirm weights kept.
        run_window(9'h003, 10, 1'b1, 1'b0, 0, 0, 0, gc, gs, lat);
        chk("bp_class", gc, 0);
        chk("bp_score", gs, -2);
        chk("bp_latency", lat, 37);
        run_window(9'h003, 0, 1'b0, 1'b0, 0, 0, 0, gc, gs, lat);
        chk("bp_after_score", gs, -2);

        // Write in the handshake cycle is used by that window.
        run_window(9'h000, 0, 1'b0, 1'b1, 3, 9, 1000, gc, gs, lat);
        chk("same_cycle_class", gc, 3);
        chk("same_cycle_score", gs, 1000);

        // Reset mid-ACCUM clears progress and weights.
        start_window(9'h1FF, 1'b0, 0, 0, 0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        pending = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        @(negedge clk);
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        run_window(9'h1FF, 0, 1'b0, 1'b0, 0, 0, 0, gc, gs, lat);
        chk("rst_mid_class", gc, 0);
        chk("rst_mid_score", gs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
